// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Brief   : 3-way register-file write-back arbiter with grant locking, a
//           1-cycle registered write port and a drop counter for beats to x0.
//           Define WB_RR_EN for a round-robin idle policy; otherwise the idle
//           policy is fixed priority 0>1>2.
// Rev     : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_valid,
  input  logic [2:0]          req_lock,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          req_ready,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [1:0]          grant_id,
  output logic [7:0]          drop_cnt
);

  localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);
  localparam logic [1:0] c_no_grant = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic [7:0]          r_lock_cnt, w_lock_cnt_nxt;
  logic [7:0]          w_cnt_inc;
  logic [1:0]          w_ptr;
  logic [2:0]          w_idle_oh;
  logic [2:0]          w_owner_oh;
  logic [2:0]          w_take;
  logic                w_acc;
  logic [1:0]          w_acc_idx;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_data;
  logic                w_drop;

  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [1:0]          r_grant_id;
  logic [7:0]          r_drop_cnt;

  // Requester index at offset 'off' from the priority start 'base' (mod 3).
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

`ifdef WB_RR_EN
  logic [1:0] r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 2'd0;
`endif

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    w_idle_oh = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      if (req_valid[rr_idx(w_ptr, 2'(k))]) w_idle_oh = 3'b001 << rr_idx(w_ptr, 2'(k));
    end
  end

  assign w_owner_oh = 3'b001 << r_owner;

  always_comb begin
    req_ready = 3'b000;
    if (!reset) begin
      if (r_state == ST_IDLE) req_ready = w_idle_oh;
      else                    req_ready = req_valid & w_owner_oh;
    end
  end

  assign w_take    = req_valid & req_ready;
  assign w_acc     = |w_take;
  assign w_acc_idx = w_take[2] ? 2'd2 : (w_take[1] ? 2'd1 : 2'd0);

  always_comb begin
    w_acc_addr = req_addr[0 +: ADDR_W];
    w_acc_data = req_data[0 +: DATA_W];
    case (w_acc_idx)
      2'd1: begin
        w_acc_addr = req_addr[ADDR_W +: ADDR_W];
        w_acc_data = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_acc_addr = req_addr[2*ADDR_W +: ADDR_W];
        w_acc_data = req_data[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign w_drop    = w_acc && (w_acc_addr == '0);
  assign w_cnt_inc = r_lock_cnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        // With LOCK_MAX==1 the first beat already exhausts the lock budget.
        if (w_acc && req_lock[w_acc_idx] && (c_lock_max > 8'd1)) begin
          w_state_nxt    = ST_LOCKED;
          w_owner_nxt    = w_acc_idx;
          w_lock_cnt_nxt = 8'd1;
        end
      end
      ST_LOCKED: begin
        if (w_acc) begin
          if (req_lock[r_owner] && (w_cnt_inc < c_lock_max)) begin
            w_lock_cnt_nxt = w_cnt_inc;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_lock_cnt_nxt = 8'd0;
          end
        end else if (!req_lock[r_owner]) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 2'd0;
      r_lock_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

`ifdef WB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (w_acc) begin
      r_ptr <= (w_acc_idx == 2'd2) ? 2'd0 : w_acc_idx + 2'd1;
    end
  end
`endif

  // Write port: dropped beats still report their grant but never write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_grant_id <= c_no_grant;
      r_drop_cnt <= 8'd0;
    end else begin
      r_rf_we    <= w_acc && !w_drop;
      r_grant_id <= w_acc ? w_acc_idx : c_no_grant;
      if (w_acc && !w_drop) begin
        r_rf_waddr <= w_acc_addr;
        r_rf_wdata <= w_acc_data;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign grant_id = r_grant_id;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Directed self-checking bench for wb_arbiter (both WB_RR_EN builds).
// Rev     : 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [2:0]          req_valid = 3'b000;
  logic [2:0]          req_lock = 3'b000;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [1:0]          grant_id;
  logic [7:0]          drop_cnt;

  logic [ADDR_W-1:0] a [3];
  logic [DATA_W-1:0] d [3];
  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        gid;
    logic [7:0]        drop;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_waddr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic [7:0]        exp_drop = 8'd0;
  int                checks = 0;
  int                errors = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check ready, push expectation, clock, pop and compare.
  task automatic step(input logic [2:0] v, input logic [2:0] l,
                      input logic [2:0] exp_rdy, input logic [1:0] exp_gid);
    exp_t e;
    exp_t got;
    req_valid = v;
    req_lock  = l;
    #1;
    check("req_ready", req_ready, exp_rdy);
    e.we  = 1'b0;
    e.gid = exp_gid;
    if (exp_gid != 2'd3) begin
      if (a[exp_gid] != '0) begin
        e.we      = 1'b1;
        exp_waddr = a[exp_gid];
        exp_wdata = d[exp_gid];
      end else if (exp_drop != 8'hFF) begin
        exp_drop = exp_drop + 8'd1;
      end
    end
    e.waddr = exp_waddr;
    e.wdata = exp_wdata;
    e.drop  = exp_drop;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("rf_we",    rf_we,    got.we);
    check("rf_waddr", rf_waddr, got.waddr);
    check("rf_wdata", rf_wdata, got.wdata);
    check("grant_id", grant_id, got.gid);
    check("drop_cnt", drop_cnt, got.drop);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_rf_we",    rf_we,     1'b0);
    check("rst_grant_id", grant_id,  2'd3);
    check("rst_drop_cnt", drop_cnt,  8'd0);
    check("rst_rf_waddr", rf_waddr,  '0);
    check("rst_rf_wdata", rf_wdata,  '0);
    check("rst_ready",    req_ready, 3'b000);
    @(posedge clk);
    #1;
    check("rst_lost_we",  rf_we,     1'b0);
    check("rst_lost_gid", grant_id,  2'd3);
    reset = 1'b0;
    #1;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_drop  = 8'd0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'h1111_0000; d[1] = 32'h2222_0000; d[2] = 32'h3333_0000;
    req_valid = 3'b111;
    pulse_reset();

    // Idle policy with everyone requesting and nobody locking.
`ifdef WB_RR_EN
    step(3'b111, 3'b000, 3'b001, 2'd0);
    step(3'b111, 3'b000, 3'b010, 2'd1);
    step(3'b111, 3'b000, 3'b100, 2'd2);
    step(3'b111, 3'b000, 3'b001, 2'd0);
`else
    for (int i = 0; i < 4; i++) step(3'b111, 3'b000, 3'b001, 2'd0);
`endif
    step(3'b000, 3'b000, 3'b000, 2'd3);

    // Lock by requester 1 shuts out requester 0.
    pulse_reset();
    a[0] = 5'd7; d[0] = 32'h70;
    a[1] = 5'd5;
    d[1] = 32'hA; step(3'b010, 3'b010, 3'b010, 2'd1);
    step(3'b001, 3'b010, 3'b000, 2'd3);
    d[1] = 32'hB; step(3'b011, 3'b010, 3'b010, 2'd1);
    d[1] = 32'hC; step(3'b011, 3'b000, 3'b010, 2'd1);
    step(3'b011, 3'b000, 3'b001, 2'd0);
    // Owner releases the lock without a beat: one dead cycle, then idle.
    d[1] = 32'hD; step(3'b010, 3'b010, 3'b010, 2'd1);
    step(3'b001, 3'b000, 3'b000, 2'd3);
    step(3'b001, 3'b000, 3'b001, 2'd0);

    // Beats to register 0 are dropped and counted with saturation.
    pulse_reset();
    a[0] = 5'd0; d[0] = 32'hDEAD;
    for (int i = 0; i < 300; i++) step(3'b001, 3'b000, 3'b001, 2'd0);
    check("drop_sat", drop_cnt, 8'd255);

    // Reset lands mid-lock while an owner beat is being offered.
    a[1] = 5'd6; d[1] = 32'h66;
    step(3'b010, 3'b010, 3'b010, 2'd1);
    req_valid = 3'b011;
    req_lock  = 3'b010;
    #1;
    check("pre_rst_ready", req_ready, 3'b010);
    #2;
    pulse_reset();
    a[0] = 5'd8; d[0] = 32'h88;
    step(3'b011, 3'b000, 3'b001, 2'd0);

    // Lock budget of 8 beats, then requester 0 gets in.
    pulse_reset();
    a[0] = 5'd4; d[0] = 32'h40;
    a[2] = 5'd9;
    for (int i = 1; i <= 8; i++) begin
      d[2] = 32'(i);
      step((i == 1) ? 3'b100 : 3'b101, 3'b100, 3'b100, 2'd2);
    end
    step(3'b101, 3'b100, 3'b001, 2'd0);
    d[2] = 32'h99;
    step(3'b100, 3'b000, 3'b100, 2'd2);
    step(3'b000, 3'b000, 3'b000, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: register-file data width.
REQ-002 Parameter ADDR_W, default 5: register-file address width.
REQ-003 Parameter LOCK_MAX, default 8: maximum consecutive locked beats, range 1..255.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  3  requester i has a write-back beat pending (0=ALU, 1=MEM, 2=MUL).
REQ-007 req_lock  in  3  requester i asks to keep the grant after the current beat.
REQ-008 req_addr  in  3*ADDR_W  requester i destination register at [i*ADDR_W +: ADDR_W].
REQ-009 req_data  in  3*DATA_W  requester i write data at [i*DATA_W +: DATA_W].
REQ-010 req_ready  out  3  combinational grant; a beat transfers when req_valid[i] & req_ready[i].
REQ-011 rf_we  out  1  register-file write enable.
REQ-012 rf_waddr  out  ADDR_W  register-file write address.
REQ-013 rf_wdata  out  DATA_W  register-file write data.
REQ-014 grant_id  out  2  index of the beat accepted in the previous cycle; 3 = none.
REQ-015 drop_cnt  out  8  saturating count of beats addressed to register 0.

Function
REQ-016 req_ready SHALL have at most one bit set, and only for a requester with req_valid set.
REQ-017 A beat accepted in cycle N SHALL drive rf_we=1, rf_waddr and rf_wdata in cycle N+1 only (one-cycle pulse, latency 1).
REQ-018 With no beat accepted in cycle N, rf_we SHALL be 0 in cycle N+1; rf_waddr/rf_wdata hold their last values.
REQ-019 A beat with address 0 SHALL complete its handshake, leave rf_we=0 next cycle, and increment drop_cnt, saturating at 255.
REQ-020 grant_id SHALL register the accepted requester index every cycle, including dropped beats; 3 when no beat was accepted.
REQ-021 State machine: IDLE (no owner) and LOCKED (owner k, lock beat counter).
REQ-022 IDLE: the grant goes to the highest-priority valid requester under the policy in REQ-033/034.
REQ-023 IDLE -> LOCKED(owner=i), counter=1: on a beat from i with req_lock[i]=1.
REQ-024 LOCKED: only the owner may receive ready; all other requesters see ready=0.
REQ-025 LOCKED, owner beat with req_lock=1: the counter increments; at LOCK_MAX the FSM goes to IDLE.
REQ-026 LOCKED, owner beat with req_lock=0: the FSM goes to IDLE after that beat.
REQ-027 LOCKED, no owner beat and req_lock[owner]=0: the FSM goes to IDLE next cycle without granting anyone that cycle.
REQ-028 Round-robin pointer: after a beat from i, priority order starts at (i+1) mod 3; the pointer updates on every accepted beat, locked or not.

Reset
REQ-029 reset SHALL force IDLE, pointer=0, lock counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=3 and drop_cnt=0 immediately, independent of clk.
REQ-030 req_ready SHALL be 0 while reset is high.
REQ-031 Reset asserted while LOCKED SHALL discard ownership; a beat accepted in the same cycle is lost (no rf_we after reset).
REQ-032 After reset deasserts, the first grant SHALL follow IDLE priority starting at requester 0.

Configuration
REQ-033 With macro WB_RR_EN defined, the IDLE grant policy SHALL be round-robin per REQ-028.
REQ-034 With WB_RR_EN undefined, the IDLE policy SHALL be fixed priority 0>1>2, with no pointer state; locking behaviour is unchanged.

Verification
REQ-035 WB_RR_EN defined, all valid, no lock, distinct addresses 1/2/3 -> grants 0,1,2,0 on consecutive cycles; rf_we=1 each following cycle with matching addr/data.
REQ-036 Req1 locked for 3 beats to addr 5 (data 0xA,0xB,0xC) while req0 valid -> req0 ready=0 throughout; req0 granted the cycle after req1's unlocked beat.
REQ-037 Beat to addr 0 -> rf_we=0 next cycle, drop_cnt=1, grant_id shows requester; 300 dropped beats -> drop_cnt=255.
REQ-038 LOCK_MAX=8, req2 holds lock for 10 beats with req0 valid -> after the 8th beat the FSM is IDLE and req0 is granted next.
REQ-039 Reset pulsed mid-lock between clock edges -> rf_we=0, grant_id=3, drop_cnt=0, req_ready=0 at once; the first post-reset grant goes to requester 0.
REQ-040 WB_RR_EN undefined, all valid continuously, no lock -> requester 0 granted every cycle; requesters 1 and 2 never granted.
